// File: rtl/score_ctrl_if.sv
// Score controller bus: add request/acknowledge handshake, clear,
// and the score/status outputs.
interface score_ctrl_if;
    logic        add_req;
    logic [7:0]  add_val;
    logic        clr;
    logic        add_ack;
    logic        busy;
    logic [23:0] points;
    logic        overflow;

    modport master (
        output add_req, add_val, clr,
        input  add_ack, busy, points, overflow
    );

    modport slave (
        input  add_req, add_val, clr,
        output add_ack, busy, points, overflow
    );
endinterface

// File: rtl/score_ctrl.sv
// Six-digit BCD score accumulator that adds one digit per cycle.
// SCORE_SAT_EN: saturate at 999999 on overflow instead of wrapping.
module score_ctrl #(
    parameter logic [23:0] INIT_SCORE = 24'h000000
) (
    input  logic         clk,
    input  logic         rst,
    score_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ADD, ACK} state_t;

    state_t      state;
    logic [23:0] shadow;
    logic [7:0]  op;
    logic        carry;
    logic [2:0]  idx;

    logic [3:0]  cur_d;
    logic [3:0]  op_d;
    logic [4:0]  sum;
    logic [4:0]  adj;
    logic [3:0]  new_d;
    logic        new_c;
    logic [23:0] final_val;

    function automatic logic [3:0] clamp(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    always_comb begin
        cur_d = shadow[{idx, 2'b00} +: 4];
        op_d  = 4'd0;
        if (idx == 3'd0)
            op_d = op[3:0];
        else if (idx == 3'd1)
            op_d = op[7:4];
        sum   = {1'b0, cur_d} + {1'b0, op_d} + {4'b0000, carry};
        adj   = sum - 5'd10;
        new_c = (sum > 5'd9);
        new_d = new_c ? adj[3:0] : sum[3:0];
    end

    // carry here is the carry out of the most significant digit
`ifdef SCORE_SAT_EN
    assign final_val = carry ? 24'h999999 : shadow;
`else
    assign final_val = shadow;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shadow       <= 24'h000000;
            op           <= 8'h00;
            carry        <= 1'b0;
            idx          <= 3'd0;
            bus.points   <= INIT_SCORE;
            bus.overflow <= 1'b0;
            bus.add_ack  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            bus.add_ack <= 1'b0;
            if (bus.clr) begin
                state        <= IDLE;
                bus.points   <= 24'h000000;
                bus.overflow <= 1'b0;
                bus.busy     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.add_req) begin
                            op       <= {clamp(bus.add_val[7:4]),
                                         clamp(bus.add_val[3:0])};
                            shadow   <= bus.points;
                            carry    <= 1'b0;
                            idx      <= 3'd0;
                            state    <= ADD;
                            bus.busy <= 1'b1;
                        end
                    end
                    ADD: begin
                        shadow[{idx, 2'b00} +: 4] <= new_d;
                        carry <= new_c;
                        if (idx == 3'd5)
                            state <= ACK;
                        else
                            idx <= idx + 3'd1;
                    end
                    ACK: begin
                        bus.points   <= final_val;
                        bus.overflow <= bus.overflow | carry;
                        bus.add_ack  <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_ctrl.sv
// Directed self-checking bench for score_ctrl (reset value 999990).
module tb_score_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    score_ctrl_if bus ();

    score_ctrl #(.INIT_SCORE(24'h999990)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs,
                       input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_add(input logic [7:0] v, input logic [23:0] ep,
                          input logic eo, input bit en);
        logic [23:0] pre;
        bit hold_ok;
        bit ack_early;
        @(negedge clk);
        bus.add_req = 1'b1;
        bus.add_val = v;
        pre = bus.points;
        @(posedge clk); #1;
        if (en) chk("busy_accept", {23'd0, bus.busy}, 24'd1);
        hold_ok = 1'b1;
        ack_early = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.points !== pre) hold_ok = 1'b0;
            if (bus.add_ack !== 1'b0) ack_early = 1'b1;
        end
        if (en) begin
            chk("points_hold", {23'd0, hold_ok}, 24'd1);
            chk("ack_early", {23'd0, ack_early}, 24'd0);
        end
        @(posedge clk); #1;
        bus.add_req = 1'b0;
        if (en) begin
            chk("ack_n7", {23'd0, bus.add_ack}, 24'd1);
            chk("points", bus.points, ep);
            chk("overflow", {23'd0, bus.overflow}, {23'd0, eo});
        end
        @(posedge clk); #1;
        if (en) chk("ack_pulse", {23'd0, bus.add_ack}, 24'd0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr = 1'b1;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        chk("clr_points", bus.points, 24'h000000);
        chk("clr_ovf", {23'd0, bus.overflow}, 24'd0);
    endtask

    initial begin
        logic [23:0] wrap_exp;
        bit seen;
        bus.add_req = 1'b0;
        bus.add_val = 8'h00;
        bus.clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_points", bus.points, 24'h999990);
        chk("rst_ovf", {23'd0, bus.overflow}, 24'd0);
        chk("rst_ack", {23'd0, bus.add_ack}, 24'd0);
        chk("rst_busy", {23'd0, bus.busy}, 24'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

`ifdef SCORE_SAT_EN
        wrap_exp = 24'h999999;
`else
        wrap_exp = 24'h000005;
`endif
        do_add(8'h15, wrap_exp, 1'b1, 1'b1);

        pulse_clr();
        do_add(8'h07, 24'h000007, 1'b0, 1'b1);

        pulse_clr();
        do_add(8'h95, 24'h000095, 1'b0, 1'b1);
        do_add(8'h27, 24'h000122, 1'b0, 1'b1);

        pulse_clr();
        for (int i = 0; i < 101; i++)
            do_add(8'h99, 24'h0, 1'b0, 1'b0);
        chk("pre_9999", bus.points, 24'h009999);
        do_add(8'h01, 24'h010000, 1'b0, 1'b1);

        // clr during the third ADD cycle
        @(negedge clk);
        bus.add_req = 1'b1;
        bus.add_val = 8'h50;
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.clr = 1'b1;
        bus.add_req = 1'b0;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        chk("midclr_points", bus.points, 24'h000000);
        chk("midclr_ovf", {23'd0, bus.overflow}, 24'd0);
        chk("midclr_busy", {23'd0, bus.busy}, 24'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.add_ack !== 1'b0) seen = 1'b1;
        end
        chk("midclr_noack", {23'd0, seen}, 24'd0);
        chk("midclr_after", bus.points, 24'h000000);

        // clr and add_req together in IDLE
        do_add(8'h07, 24'h000007, 1'b0, 1'b1);
        @(negedge clk);
        bus.clr = 1'b1;
        bus.add_req = 1'b1;
        bus.add_val = 8'h42;
        @(posedge clk); #1;
        bus.clr = 1'b0;
        chk("clrwin_points", bus.points, 24'h000000);
        chk("clrwin_busy", {23'd0, bus.busy}, 24'd0);
        @(posedge clk); #1;
        chk("clrwin_accept", {23'd0, bus.busy}, 24'd1);
        repeat (6) @(posedge clk);
        @(posedge clk); #1;
        bus.add_req = 1'b0;
        chk("clrwin_ack", {23'd0, bus.add_ack}, 24'd1);
        chk("clrwin_sum", bus.points, 24'h000042);
        @(posedge clk); #1;

        pulse_clr();
        do_add(8'hAF, 24'h000099, 1'b0, 1'b1);

        // add_req held past add_ack starts a second addition
        @(negedge clk);
        bus.add_req = 1'b1;
        bus.add_val = 8'h01;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        chk("b2b_ack1", {23'd0, bus.add_ack}, 24'd1);
        chk("b2b_sum1", bus.points, 24'h000100);
        @(posedge clk); #1;
        bus.add_req = 1'b0;
        chk("b2b_accept2", {23'd0, bus.busy}, 24'd1);
        repeat (7) @(posedge clk);
        #1;
        chk("b2b_ack2", {23'd0, bus.add_ack}, 24'd1);
        chk("b2b_sum2", bus.points, 24'h000101);
        @(posedge clk); #1;

        // reset in the middle of ADD
        @(negedge clk);
        bus.add_req = 1'b1;
        bus.add_val = 8'h11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.add_req = 1'b0;
        #1;
        chk("midrst_points", bus.points, 24'h999990);
        chk("midrst_busy", {23'd0, bus.busy}, 24'd0);
        chk("midrst_ack", {23'd0, bus.add_ack}, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.add_ack !== 1'b0) seen = 1'b1;
        end
        chk("midrst_noack", {23'd0, seen}, 24'd0);
        chk("midrst_after", bus.points, 24'h999990);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
